// File: rtl/fir_pkg.sv
// Shared FIR datapath definitions: opcodes, coefficient word type and the
// coefficient writer state encoding.
package fir_pkg;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_LOAD1 = 3'b010;

    typedef logic [15:0] coeff_word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_SETTLE,
        ST_ACK
    } writer_state_e;

endpackage

// File: rtl/coefficient_writer_if.sv
// Loader-to-writer handshake: request, index, value and the busy return.
interface coefficient_writer_if;
    import fir_pkg::*;

    logic        load_coeff;
    logic [1:0]  coefficient_num;
    coeff_word_t coeff_value;
    logic        modwait;

    modport master (output load_coeff, coefficient_num, coeff_value, input modwait);
    modport slave  (input load_coeff, coefficient_num, coeff_value, output modwait);

endinterface

// File: rtl/coeff_settle_timer.sv
// Loadable down-counter that stops at zero and flags when it is there.
module coeff_settle_timer #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/coefficient_writer.sv
// Turns each loader request into one LOAD1 datapath write, holds the loader
// off until the write has settled, and tracks which coefficients are resident.
module coefficient_writer
    import fir_pkg::*;
#(
    parameter int unsigned NUM_COEFFS     = 4,
    parameter int unsigned SETTLE_CYCLES  = 2,
    parameter logic [3:0]  COEFF_BASE_REG = 4'd6
) (
    input  logic                    clk,
    input  logic                    rst,
    coefficient_writer_if.slave     ldr,
    input  logic                    clear_set,
    output logic [2:0]              dp_op,
    output logic [3:0]              dest_reg,
    output coeff_word_t             ext_data,
    output logic [NUM_COEFFS-1:0]   written_mask,
    output logic                    coeff_set_done,
    output logic                    collision_err
);

    localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES) + 1;

    writer_state_e         state_q, state_d;
    logic [1:0]            idx_q, idx_d;
    coeff_word_t           val_q, val_d;
    logic [3:0]            dest_q, dest_d;
    logic [NUM_COEFFS-1:0] mask_q, mask_d, mask_base, ack_bit;
    logic                  done_q, done_d;
    logic                  coll_q, coll_d;
    logic                  tmr_load, tmr_dec, tmr_zero;

    coeff_settle_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (CNT_W'(SETTLE_CYCLES - 1)),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        val_d     = val_q;
        dest_d    = dest_q;
        done_d    = 1'b0;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;

        // Out-of-range indices select no bit, so the mask is left untouched.
        ack_bit = '0;
        for (int unsigned k = 0; k < NUM_COEFFS; k++) begin
            if (32'(idx_q) == k) begin
                ack_bit[k] = 1'b1;
            end
        end

        // clear_set takes effect before any ACK bit or collision in the same cycle.
        mask_base = clear_set ? '0 : mask_q;
        mask_d    = mask_base;
        coll_d    = clear_set ? 1'b0 : coll_q;

        case (state_q)
            ST_IDLE: begin
                if (ldr.load_coeff) begin
                    idx_d   = ldr.coefficient_num;
                    val_d   = ldr.coeff_value;
                    dest_d  = COEFF_BASE_REG + {2'b00, ldr.coefficient_num};
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                tmr_load = 1'b1;
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (tmr_zero) begin
                    state_d = ST_ACK;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_ACK: begin
                mask_d  = mask_base | ack_bit;
                done_d  = (&mask_d) && !(&mask_base);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (ldr.load_coeff && (state_q != ST_IDLE)) begin
            coll_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            val_q   <= '0;
            dest_q  <= '0;
            mask_q  <= '0;
            done_q  <= 1'b0;
            coll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            val_q   <= val_d;
            dest_q  <= dest_d;
            mask_q  <= mask_d;
            done_q  <= done_d;
            coll_q  <= coll_d;
        end
    end

    assign ldr.modwait    = (state_q != ST_IDLE);
    assign dp_op          = (state_q == ST_WRITE) ? OP_LOAD1 : OP_NOP;
    assign dest_reg       = dest_q;
    assign ext_data       = val_q;
    assign written_mask   = mask_q;
    assign coeff_set_done = done_q;
    assign collision_err  = coll_q;

endmodule

// File: tb/tb_coefficient_writer.sv
// Bench for coefficient_writer: default build plus a NUM_COEFFS=3, SETTLE_CYCLES=1 build.
module tb_coefficient_writer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear_set = 1'b0;
    always #5 clk = ~clk;

    coefficient_writer_if ifa ();
    coefficient_writer_if ifb ();

    logic [2:0]  a_op, b_op;
    logic [3:0]  a_dest, b_dest;
    logic [15:0] a_ext, b_ext;
    logic [3:0]  a_mask;
    logic [2:0]  b_mask;
    logic        a_done, b_done, a_coll, b_coll;

    coefficient_writer u_dut_a (
        .clk(clk), .rst(rst), .ldr(ifa.slave), .clear_set(clear_set),
        .dp_op(a_op), .dest_reg(a_dest), .ext_data(a_ext), .written_mask(a_mask),
        .coeff_set_done(a_done), .collision_err(a_coll)
    );

    coefficient_writer #(.NUM_COEFFS(3), .SETTLE_CYCLES(1), .COEFF_BASE_REG(4'd6)) u_dut_b (
        .clk(clk), .rst(rst), .ldr(ifb.slave), .clear_set(clear_set),
        .dp_op(b_op), .dest_reg(b_dest), .ext_data(b_ext), .written_mask(b_mask),
        .coeff_set_done(b_done), .collision_err(b_coll)
    );

    // Observation mux selects which build the checks look at.
    logic        sel = 1'b0;
    logic        obs_mw, obs_done, obs_coll;
    logic [2:0]  obs_op;
    logic [3:0]  obs_dest, obs_mask;
    logic [15:0] obs_ext;
    assign obs_mw   = sel ? ifb.modwait : ifa.modwait;
    assign obs_op   = sel ? b_op : a_op;
    assign obs_dest = sel ? b_dest : a_dest;
    assign obs_ext  = sel ? b_ext : a_ext;
    assign obs_mask = sel ? {1'b0, b_mask} : a_mask;
    assign obs_done = sel ? b_done : a_done;
    assign obs_coll = sel ? b_coll : a_coll;

    typedef struct { logic [3:0] dest; logic [15:0] data; } sb_t;
    sb_t sb[$];

    typedef struct { logic [1:0] num; logic [15:0] val; logic [3:0] mask; logic done; } vec_t;
    vec_t tbl[5];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic observe();
        sb_t e;
        if (obs_op == 3'b010) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got dest %0h data %0h expected none at %0t",
                         obs_dest, obs_ext, $time);
            end else begin
                e = sb.pop_front();
                check("wr_dest", 32'(obs_dest), 32'(e.dest));
                check("wr_data", 32'(obs_ext), 32'(e.data));
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        observe();
    endtask

    task automatic drive(input logic ld, input logic [1:0] num, input logic [15:0] val);
        if (sel) begin
            ifb.load_coeff = ld; ifb.coefficient_num = num; ifb.coeff_value = val;
        end else begin
            ifa.load_coeff = ld; ifa.coefficient_num = num; ifa.coeff_value = val;
        end
    endtask

    task automatic expect_write(input logic [1:0] num, input logic [15:0] val);
        sb_t e;
        e.dest = 4'(6 + num);
        e.data = val;
        sb.push_back(e);
    endtask

    // Load issued now; modwait must stay high for win-1 cycles and drop at t+win.
    task automatic run_load(input logic [1:0] num, input logic [15:0] val, input int unsigned win,
                            input logic [3:0] exp_mask, input logic exp_done);
        int unsigned pulses = 0;
        drive(1'b1, num, val);
        expect_write(num, val);
        for (int unsigned k = 1; k <= win; k++) begin
            step();
            if (k == 1) drive(1'b0, 2'd0, 16'h0);
            pulses += 32'(obs_done);
            check("modwait_window", 32'(obs_mw), 32'(k < win));
        end
        check("mask", 32'(obs_mask), 32'(exp_mask));
        check("done_at_ack", 32'(obs_done), 32'(exp_done));
        check("done_pulses", pulses, 32'(exp_done));
    endtask

    task automatic do_clear();
        clear_set = 1'b1;
        step();
        clear_set = 1'b0;
        check("clear_mask", 32'(obs_mask), 32'h0);
        check("clear_coll", 32'(obs_coll), 32'h0);
    endtask

    initial begin
        tbl[0] = '{num: 2'd0, val: 16'hAAAA, mask: 4'b0001, done: 1'b0};
        tbl[1] = '{num: 2'd1, val: 16'hBBBB, mask: 4'b0011, done: 1'b0};
        tbl[2] = '{num: 2'd2, val: 16'hCCCC, mask: 4'b0111, done: 1'b0};
        tbl[3] = '{num: 2'd3, val: 16'hDDDD, mask: 4'b1111, done: 1'b1};
        tbl[4] = '{num: 2'd1, val: 16'hEEEE, mask: 4'b1111, done: 1'b0};

        drive(1'b0, 2'd0, 16'h0);
        sel = 1'b1;
        drive(1'b0, 2'd0, 16'h0);
        sel = 1'b0;

        // Reset values
        step();
        step();
        check("rst_modwait", 32'(obs_mw), 32'h0);
        check("rst_dp_op", 32'(obs_op), 32'h0);
        check("rst_dest", 32'(obs_dest), 32'h0);
        check("rst_ext", 32'(obs_ext), 32'h0);
        check("rst_mask", 32'(obs_mask), 32'h0);
        check("rst_done", 32'(obs_done), 32'h0);
        check("rst_coll", 32'(obs_coll), 32'h0);
        rst = 1'b0;
        step();
        check("post_rst_done", 32'(obs_done), 32'h0);

        // Single load of index 2
        run_load(2'd2, 16'h1234, 5, 4'b0100, 1'b0);
        check("dest_held", 32'(obs_dest), 32'h8);
        do_clear();

        // Full set, each load issued on the first idle cycle, then a rewrite
        for (int i = 0; i < 5; i++) begin
            run_load(tbl[i].num, tbl[i].val, 5, tbl[i].mask, tbl[i].done);
        end
        step();
        check("no_late_done", 32'(obs_done), 32'h0);
        do_clear();

        // Collision: second request at t+2 is dropped
        drive(1'b1, 2'd0, 16'h1111);
        expect_write(2'd0, 16'h1111);
        step();
        drive(1'b0, 2'd0, 16'h0);
        step();
        drive(1'b1, 2'd1, 16'h2222);
        step();
        drive(1'b0, 2'd0, 16'h0);
        check("coll_set", 32'(obs_coll), 32'h1);
        step();
        step();
        check("coll_modwait", 32'(obs_mw), 32'h0);
        check("coll_mask", 32'(obs_mask), 32'b0001);
        check("coll_sticky", 32'(obs_coll), 32'h1);
        do_clear();

        // clear_set coincident with the ACK of index 3
        run_load(2'd0, 16'h0A0A, 5, 4'b0001, 1'b0);
        run_load(2'd1, 16'h0B0B, 5, 4'b0011, 1'b0);
        run_load(2'd2, 16'h0C0C, 5, 4'b0111, 1'b0);
        drive(1'b1, 2'd3, 16'h7777);
        expect_write(2'd3, 16'h7777);
        step();
        drive(1'b0, 2'd0, 16'h0);
        step();
        drive(1'b1, 2'd0, 16'h9999);
        step();
        drive(1'b0, 2'd0, 16'h0);
        check("ackclr_coll_pre", 32'(obs_coll), 32'h1);
        step();
        check("ackclr_mask_pre", 32'(obs_mask), 32'b0111);
        clear_set = 1'b1;
        step();
        clear_set = 1'b0;
        check("ackclr_mask", 32'(obs_mask), 32'b1000);
        check("ackclr_coll", 32'(obs_coll), 32'h0);
        check("ackclr_done", 32'(obs_done), 32'h0);
        check("ackclr_modwait", 32'(obs_mw), 32'h0);
        step();
        check("ackclr_done2", 32'(obs_done), 32'h0);

        // Reset for two cycles in SETTLE aborts the write
        drive(1'b1, 2'd1, 16'h5555);
        expect_write(2'd1, 16'h5555);
        step();
        drive(1'b1, 2'd2, 16'h6666);
        step();
        drive(1'b0, 2'd0, 16'h0);
        check("mid_coll", 32'(obs_coll), 32'h1);
        check("mid_settle_op", 32'(obs_op), 32'h0);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("mid_rst_modwait", 32'(obs_mw), 32'h0);
            check("mid_rst_op", 32'(obs_op), 32'h0);
            check("mid_rst_mask", 32'(obs_mask), 32'h0);
            check("mid_rst_coll", 32'(obs_coll), 32'h0);
            check("mid_rst_done", 32'(obs_done), 32'h0);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("no_ack_modwait", 32'(obs_mw), 32'h0);
            check("no_ack_mask", 32'(obs_mask), 32'h0);
            check("no_ack_done", 32'(obs_done), 32'h0);
        end

        // SETTLE_CYCLES=1, NUM_COEFFS=3 build; index 3 is out of range
        sel = 1'b1;
        step();
        run_load(2'd2, 16'h2222, 4, 4'b0100, 1'b0);
        run_load(2'd3, 16'h3333, 4, 4'b0100, 1'b0);
        run_load(2'd0, 16'h4444, 4, 4'b0101, 1'b0);
        run_load(2'd1, 16'h5555, 4, 4'b0111, 1'b1);
        step();
        check("b_done_once", 32'(obs_done), 32'h0);

        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
